// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// The optional IMEM_LOADER_CHECKSUM_EN build uses the CHK state.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DAT_LO = 3'd2,
        DAT_HI = 3'd3,
        CHK    = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    localparam int INSTR_W   = 16;
    localparam int PC_STRIDE = 2;

endpackage

// File: rtl/imem_loader_asm.sv
// Byte-to-word assembler: latches the low byte and emits a registered
// one-cycle word-valid pulse with the little-endian word {hi, lo}.
module imem_loader_asm
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               lo_en,
    input  logic               hi_en,
    input  logic [7:0]         in_byte,
    output logic [7:0]         lo_q,
    output logic               word_vld,
    output logic [INSTR_W-1:0] word
);

    // Low-byte latch, word register and the one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            lo_q     <= '0;
            word_vld <= 1'b0;
            word     <= '0;
        end else begin
            word_vld <= hi_en;
            if (lo_en) lo_q <= in_byte;
            if (hi_en) word <= {in_byte, lo_q};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a little-endian word count
// and data stream, writes words at stride 2, and holds the CPU in reset
// until the image is in memory. Define IMEM_LOADER_CHECKSUM_EN to require
// a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic              rearm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_written
);

    localparam logic [15:0]       MAX_N  = 16'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(PC_STRIDE);

    state_t      state;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [7:0]  lo_q;
    logic [15:0] hdr_n;
    logic        xfer;
    logic        word_vld;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    // Ready is a pure decode of the state so it never depends on in_valid
    assign in_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DAT_LO) ||
                      (state == DAT_HI) || (state == CHK);
    assign xfer     = in_valid && in_ready;
    assign hdr_n    = {in_byte, lo_q};
    assign imem_we  = word_vld;

    imem_loader_asm u_asm (
        .clk      (clk),
        .reset    (reset),
        .lo_en    (xfer && (state == HDR_LO || state == DAT_LO)),
        .hi_en    (xfer && (state == DAT_HI)),
        .in_byte  (in_byte),
        .lo_q     (lo_q),
        .word_vld (word_vld),
        .word     (imem_wdata)
    );

    // Load FSM with address/word counters; rearm overrides the post-write bump
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HDR_LO;
            cpu_hold      <= 1'b1;
            imem_addr     <= BASE_ADDR;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
            n_words       <= '0;
            word_idx      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
        end else begin
            // Address/count advance the cycle after the strobe
            if (word_vld) begin
                imem_addr     <= imem_addr + STRIDE;
                words_written <= words_written + 16'd1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (xfer && state != CHK) csum <= csum ^ in_byte;
`endif
            case (state)
                HDR_LO: if (xfer) state <= HDR_HI;
                HDR_HI: if (xfer) begin
                    n_words  <= hdr_n;
                    word_idx <= '0;
                    if (hdr_n == 16'd0) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else if (hdr_n > MAX_N) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else begin
                        state <= DAT_LO;
                    end
                end
                DAT_LO: if (xfer) state <= DAT_HI;
                DAT_HI: if (xfer) begin
                    word_idx <= word_idx + 16'd1;
                    if (word_idx == n_words - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= CHK;
`else
                        // Release lands in the same cycle as the final strobe
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state <= DAT_LO;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: if (xfer) begin
                    if (in_byte == csum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
`endif
                DONE, ERROR: if (rearm) begin
                    state         <= HDR_LO;
                    done          <= 1'b0;
                    error         <= 1'b0;
                    words_written <= '0;
                    imem_addr     <= BASE_ADDR;
                    cpu_hold      <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum          <= '0;
`endif
                end
                default: state <= HDR_LO;
            endcase
        end
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory. The processor core only ever reads that memory.
- Accepts a byte stream through a valid/ready handshake and assembles 16-bit instruction words.
- Writes each word into instruction memory at byte addresses that advance by 2, matching the PC stride.
- Holds the CPU in reset until the image is complete.
- Sits between the host/serial front end and the instruction-memory write port (write-enable = 1 means write).

Parameters:
- ADDR_W, 16: width of the instruction-memory byte address.
- BASE_ADDR, 16'h0000: byte address of the first loaded word.
- MAX_WORDS, 256: largest legal word count. A header above this is an error.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_byte holds a valid byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- rearm  input  1  restart loading from DONE or ERROR.
- imem_we  output  1  one-cycle instruction-memory write strobe.
- imem_addr  output  ADDR_W  write byte address.
- imem_wdata  output  16  write data.
- cpu_hold  output  1  drives CPU reset (1 = hold in reset).
- done  output  1  image loaded successfully.
- error  output  1  load failed.
- words_written  output  16  count of words committed.

Behaviour:
- Reset: one clock, synchronous, active-high. Polarity and synchronicity are fixed.
- Reset values:
  - state = HDR_LO, cpu_hold = 1.
  - imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0.
  - done = 0, error = 0, words_written = 0.
  - Reset mid-load abandons the load; no further writes are issued.
- Byte transfer: a byte moves only when in_valid && in_ready.
  - in_ready = 1 in HDR_LO, HDR_HI, DAT_LO, DAT_HI and CHK.
  - in_ready = 0 in DONE and ERROR.
  - in_ready is decoded from state only, never from in_valid.
- Stream format, all little-endian (low byte first):
  - Word count N: two bytes.
  - Then N instruction words, two bytes each.
- FSM transitions:
  - HDR_LO: take the count low byte -> HDR_HI.
  - HDR_HI: form N.
    - N == 0 -> DONE.
    - N > MAX_WORDS -> ERROR.
    - Otherwise -> DAT_LO.
  - DAT_LO: latch the low byte -> DAT_HI.
  - DAT_HI: on acceptance, register the write.
    - Next cycle: imem_we = 1 for exactly one cycle, imem_wdata = {hi, lo}, imem_addr = current address.
    - Then the address advances by 2 (ADDR_W-bit wrap) and words_written increments.
    - If this is word N -> DONE (or CHK when the option is compiled in); otherwise -> DAT_LO.
  - DONE: done = 1, cpu_hold = 0.
  - ERROR: error = 1, cpu_hold = 1.
  - rearm=1 in DONE or ERROR:
    - Next state HDR_LO.
    - done, error and words_written clear; imem_addr returns to BASE_ADDR; cpu_hold = 1.
  - rearm is ignored in every other state.
- Write latency:
  - The write strobe is one cycle after the high-byte handshake.
  - A new byte may be accepted in the same cycle imem_we is high; there is no stall.
- Back-to-back bytes: full throughput, one byte per cycle. Gaps (in_valid = 0) are allowed anywhere.
- Release timing: cpu_hold drops in the same cycle as the final write strobe, so the CPU leaves reset only after the last word is in memory.
- Words are written in order; no address is written twice within one load.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte the FSM enters CHK and accepts one checksum byte.
  - The checksum byte must equal the XOR of every count and data byte in the stream.
  - Match -> DONE. Mismatch -> ERROR, with cpu_hold remaining 1.
  - Words already written are not rolled back.
- Not defined:
  - The CHK state and the running XOR register are absent.
  - The last data word goes directly to DONE.

Decomposition:
- Shared package contents:
  - FSM state encoding: HDR_LO, HDR_HI, DAT_LO, DAT_HI, CHK, DONE, ERROR.
  - Instruction word width (16) and PC stride constant (2).
- Sub-module: imem_loader_asm assembles two bytes into one word. It holds the low-byte latch and produces a registered word-valid pulse.
- The FSM, address counter and word counter stay in imem_loader.

Test Plan:
- Basic load: after reset, send 02 00 34 12 78 56 with no gaps, BASE_ADDR=0. Two writes: (0x0000, 0x1234), then (0x0002, 0x5678). done=1, cpu_hold=0, words_written=2.
- Empty image: send 00 00. No imem_we pulse; DONE in the cycle after the second byte.
- Oversize count: send 01 02 (N=0x0201 > 256). ERROR, error=1, cpu_hold=1, no writes. Then rearm=1 -> in_ready=1 in HDR_LO, and a fresh load succeeds.
- Gapped stream with random in_valid holes: same write sequence and values as the basic load. in_ready stays 1 during the gaps.
- Reset mid-load: assert reset after the 3rd data byte of an N=4 image. Outputs return to their reset values, no pending write issues, and a subsequent clean load starts again at BASE_ADDR.
- IMEM_LOADER_CHECKSUM_EN, valid checksum: send 01 00 CD AB followed by the XOR of 01^00^CD^AB = 0x67. Result DONE, one write of 0xABCD. Sending checksum 0x68 instead -> ERROR, cpu_hold=1.
